// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data memory responder: FSM states
// and the widths the responder, its interface and the storage agree on.
package mips_mem_pkg;

   localparam int DATA_W_DEFAULT = 32;
   localparam int ADDR_W         = 32;
   localparam int WAIT_CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory responder (slave).
interface dmem_responder_if
   import mips_mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
);

   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_abort;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              stall;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_abort,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_abort,
      output req_ready, resp_valid, resp_rdata, resp_err, stall
   );

endinterface

// File: rtl/dmem_word_array.sv
// Word storage with synchronous write and registered read; the read
// register only updates on a read access, so it holds between accesses.
module dmem_word_array #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
   logic [DATA_W-1:0] rdata_d, rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) rdata_d = mem_q[idx];
   end

   // NOTE: storage and its read register carry no reset so they map onto
   // RAM macros; the responder masks the read data until a load completes.
   always_ff @(posedge clk) begin
      if (en && we) mem_q[idx] <= wdata;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: accepts one load/store at a time,
// inserts WAIT_CYCLES wait states, then pulses a single response.
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEFAULT,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_responder_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

   state_e                state_d, state_q;
   logic [WAIT_CNT_W-1:0] cnt_d, cnt_q;
   logic                  write_d, write_q;
   logic [ADDR_W-1:0]     addr_d, addr_q;
   logic [DATA_W-1:0]     wdata_d, wdata_q;
   logic                  err_d, err_q;
   logic                  load_ok_d, load_ok_q;

   logic                  acc_fire;
   logic                  acc_write;
   logic [ADDR_W-1:0]     acc_addr;
   logic [DATA_W-1:0]     acc_wdata;
   logic                  acc_err;
   logic [DATA_W-1:0]     arr_rdata;

   // With zero wait states the access happens on the accepting edge, so it
   // must use the live request rather than the latched copy.
   assign acc_write = (state_q == IDLE) ? bus.req_write : write_q;
   assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
   assign acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (IDX_W + 2)) != '0);

   // NOTE: every signal gets its default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      load_ok_d = load_ok_q;
      acc_fire  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = WAIT_INIT;
               if (WAIT_CYCLES == 0) begin
                  acc_fire = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Abort beats an access falling on the same edge.
            if (bus.req_abort) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  acc_fire = 1'b1;
                  state_d  = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (acc_fire) begin
         err_d     = acc_err;
         load_ok_d = !acc_err && !acc_write;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         load_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         load_ok_q <= load_ok_d;
      end
   end

   dmem_word_array #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (acc_fire && !acc_err),
      .we    (acc_write),
      .idx   (acc_addr[IDX_W+1:2]),
      .wdata (acc_wdata),
      .rdata (arr_rdata)
   );

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = load_ok_q ? arr_rdata : '0;
   assign bus.resp_err   = err_q;
   assign bus.stall      = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);

endmodule
